// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the sp_ram_arbiter controller.
// Optional feature macro used by this codebase slice: SP_RAM_ARB_PRIO_EN.
package sp_ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic port_id_t;

  localparam int unsigned RAM_SIZE_DEFAULT = 32768;
  localparam int unsigned WORD_COUNT       = RAM_SIZE_DEFAULT / 4;
  localparam logic [3:0]  BE_ALL           = 4'hF;

  // Number of 32-bit words in a RAM of the given byte size.
  function automatic int unsigned word_count(input int unsigned ram_size);
    return ram_size / 4;
  endfunction

endpackage

// File: rtl/sp_ram_arb_rr.sv
// Two-requester grant logic for sp_ram_arbiter: round-robin by default, or fixed
// priority for port 0 with a port-1 starvation counter when SP_RAM_ARB_PRIO_EN is defined.
module sp_ram_arb_rr
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic p1_wins;

`ifdef SP_RAM_ARB_PRIO_EN
  localparam logic [2:0] MaxWait = 3'(MAX_WAIT);

  logic [2:0] wait_q, wait_d;

  // Port 1 only wins a contested cycle once it has waited MAX_WAIT cycles.
  assign p1_wins = (wait_q >= MaxWait);

  always_comb begin
    wait_d = wait_q;
    if (gnt[1]) begin
      wait_d = '0;
    end else if (en && req[1] && !p1_wins) begin
      wait_d = wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  // ptr_q names the port favoured on the next contested cycle.
  port_id_t ptr_q, ptr_d;

  assign p1_wins = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = p1_wins ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Controller sharing one single-port RAM between two req/gnt/rvalid requesters, with
// optional zero-fill after reset. Arbitration mode selected by SP_RAM_ARB_PRIO_EN.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE       = 32768,
  parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned MAX_WAIT       = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  output logic                  init_done_o,

  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [3:0]            p0_be_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,

  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [3:0]            p1_be_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,

  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned NumWords   = word_count(RAM_SIZE);
  localparam int unsigned CntWidth   = ADDR_WIDTH - 2;
  localparam state_e      ResetState = (CLEAR_ON_RESET != 0) ? INIT : RUN;
  localparam logic [CntWidth-1:0] LastWord = CntWidth'(NumWords - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [1:0]          rvalid_q;
  logic [1:0]          gnt;
  logic                run_en;

  // Init/run sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_q == LastWord) begin
          state_d = RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = ResetState;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      done_q  <= (ResetState == RUN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign init_done_o = done_q;

  // Grants are suppressed while reset is held so every port output reads zero.
  assign run_en = (state_q == RUN) && !rst_i;

  sp_ram_arb_rr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_rr (
    .clk   (clk),
    .rst_i (rst_i),
    .en    (run_en),
    .req   ({p1_req_i, p0_req_i}),
    .gnt   (gnt)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  // RAM request mux: fill pattern during INIT, else the granted port.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = p0_addr_i;
    mem_we_o    = p0_we_i;
    mem_be_o    = p0_be_i;
    mem_wdata_o = p0_wdata_i;
    if (rst_i) begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
    end else if (state_q == INIT) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = {cnt_q, 2'b00};
      mem_we_o    = 1'b1;
      mem_be_o    = BE_ALL;
      mem_wdata_o = '0;
    end else if (gnt[1]) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = p1_addr_i;
      mem_we_o    = p1_we_i;
      mem_be_o    = p1_be_i;
      mem_wdata_o = p1_wdata_i;
    end else if (gnt[0]) begin
      mem_en_o    = 1'b1;
    end
  end

  // Response pipeline matches the RAM's single-cycle read latency.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
    end
  end

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = rvalid_q[0] ? mem_rdata_i : '0;
  assign p1_rdata_o  = rvalid_q[1] ? mem_rdata_i : '0;

endmodule
